// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock, signed product
// of two WIDTH-bit operands after WIDTH steps, with add/subtract step counters.
module booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inp,
  input  logic signed [WIDTH-1:0]     mcand,
  input  logic signed [WIDTH-1:0]     mplier,
  output logic signed [2*WIDTH-1:0]   prod,
  output logic        [31:0]          count_add,
  output logic        [31:0]          count_sub,
  output logic                        done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // A carries one guard bit so A-M cannot overflow even for the most negative mcand
  logic signed [WIDTH:0]   m_r;
  logic signed [WIDTH:0]   a_r;
  logic        [WIDTH-1:0] q_r;
  logic                    q_1;
  logic        [CNT_W-1:0] cnt;

  logic                    start;
  logic                    last;
  logic        [1:0]       booth_sel;
  logic signed [WIDTH:0]   a_sum;
  logic signed [WIDTH:0]   a_shf;
  logic        [WIDTH-1:0] q_shf;

  function automatic logic signed [WIDTH:0] booth_step(
    input logic        [1:0]   sel,
    input logic signed [WIDTH:0] a,
    input logic signed [WIDTH:0] m
  );
    case (sel)
      2'b01:   return a + m;
      2'b10:   return a - m;
      default: return a;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (inp) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign booth_sel = {q_r[0], q_1};
  assign a_sum     = booth_step(booth_sel, a_r, m_r);
  assign a_shf     = a_sum >>> 1;
  assign q_shf     = {a_sum[0], q_r[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r       <= '0;
      a_r       <= '0;
      q_r       <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      count_add <= '0;
      count_sub <= '0;
      done      <= 1'b0;
    end else if (start) begin
      m_r       <= {mcand[WIDTH-1], mcand};
      a_r       <= '0;
      q_r       <= mplier;
      q_1       <= 1'b0;
      cnt       <= CNT_W'(WIDTH);
      count_add <= '0;
      count_sub <= '0;
      done      <= 1'b0;
    end else if (state == RUN) begin
      a_r <= a_shf;
      q_r <= q_shf;
      q_1 <= q_r[0];
      cnt <= cnt - CNT_W'(1);
      if (booth_sel == 2'b01) count_add <= count_add + 32'd1;
      if (booth_sel == 2'b10) count_sub <= count_sub + 32'd1;
      if (last) begin
        prod <= {a_shf[WIDTH-1:0], q_shf};
        done <= 1'b1;
      end
    end
  end

endmodule
